// File: rtl/alu_seq_pkg.sv
// Shared constants, op classifiers and FSM state type for the ALU op sequencer.
// Contents: datapath widths, OP_* encodings, flag bit indices, state_e.
package alu_seq_pkg;

  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned OP_W  = 3;

  // Op encodings: 00x adder, 101/110 logic, everything else shifter
  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_SHL = 3'b010;
  localparam logic [OP_W-1:0] OP_SHR = 3'b011;
  localparam logic [OP_W-1:0] OP_ROL = 3'b100;
  localparam logic [OP_W-1:0] OP_AND = 3'b101;
  localparam logic [OP_W-1:0] OP_OR  = 3'b110;
  localparam logic [OP_W-1:0] OP_ROR = 3'b111;

  // Bit positions inside the {N,V,C,Z} flag vector
  localparam int unsigned F_N = 3;
  localparam int unsigned F_V = 2;
  localparam int unsigned F_C = 1;
  localparam int unsigned F_Z = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_adder(input logic [OP_W-1:0] op);
    return op[2:1] == 2'b00;
  endfunction

  function automatic logic is_logic(input logic [OP_W-1:0] op);
    return (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_shift(input logic [OP_W-1:0] op);
    return !is_adder(op) && !is_logic(op);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle between the control path and the sequencer.
// master: requester side (drives req_*, rsp_ready); slave: sequencer side.
interface alu_seq_if;
  import alu_seq_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [OP_W-1:0]  req_op;
  logic [W-1:0]     req_a;
  logic [W-1:0]     req_b;
  logic [CNT_W-1:0] req_cnt;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_y;
  logic [3:0]       rsp_nvcz;

  modport master (
    output req_valid, req_op, req_a, req_b, req_cnt, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_nvcz
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cnt, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_nvcz
  );

endinterface

// File: rtl/alu_seq_rsp_reg.sv
// Response register: holds final Y/flags and rsp_valid until consumed.
// Optional macro ALU_SEQ_CARRY_CHAIN_EN adds a carry register (carry_ld/carry ports)
// that remembers the C flag of the last completed adder op.
// Ports: clk, rst, capture (last pass), consume (rsp accepted), y_in, nvcz_in,
//        rsp_y, rsp_nvcz, rsp_valid.
module alu_seq_rsp_reg
  import alu_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
`ifdef ALU_SEQ_CARRY_CHAIN_EN
  input  logic         carry_ld,
  output logic         carry,
`endif
  input  logic         capture,
  input  logic         consume,
  input  logic [W-1:0] y_in,
  input  logic [3:0]   nvcz_in,
  output logic [W-1:0] rsp_y,
  output logic [3:0]   rsp_nvcz,
  output logic         rsp_valid
);

  // Result capture; flags are those of the final pass only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_y     <= '0;
      rsp_nvcz  <= '0;
      rsp_valid <= 1'b0;
    end else if (capture) begin
      rsp_y     <= y_in;
      rsp_nvcz  <= nvcz_in;
      rsp_valid <= 1'b1;
    end else if (consume) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  // Carry for multi-byte chaining; only adder ops update it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry <= 1'b0;
    end else if (capture && carry_ld) begin
      carry <= nvcz_in[F_C];
    end
  end
`endif

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences the combinational ALU for one requester: accepts an op, drives the ALU,
// repeats shifter ops req_cnt+1 times by feeding Y back into A, then returns the
// final Y and {N,V,C,Z}. FSM IDLE->EXEC->DONE->IDLE.
// Ports: clk, rst (async, active high), bus (alu_seq_if.slave request/response),
//        alu_op/alu_a/alu_b/alu_cin to ALU, alu_y/alu_nvcz from ALU, busy.
// Optional macro ALU_SEQ_CARRY_CHAIN_EN: feed last adder carry into alu_cin.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  alu_seq_if.slave        bus,
  output logic [OP_W-1:0] alu_op,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic            alu_cin,
  input  logic [W-1:0]    alu_y,
  input  logic [3:0]      alu_nvcz,
  output logic            busy
);

  state_e           state;
  logic [CNT_W-1:0] remaining;
  logic             capture;
  logic             consume;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
  logic             carry;
`endif

  assign bus.req_ready = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign capture       = (state == S_EXEC) && (remaining == '0);
  assign consume       = (state == S_DONE) && bus.rsp_ready;

  // Control FSM and registered ALU drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      alu_cin   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            alu_op    <= bus.req_op;
            alu_a     <= bus.req_a;
            alu_b     <= bus.req_b;
            remaining <= is_shift(bus.req_op) ? bus.req_cnt : '0;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
            alu_cin   <= is_adder(bus.req_op) & carry;
`endif
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (remaining == '0) begin
`ifdef ALU_SEQ_CARRY_CHAIN_EN
            alu_cin <= 1'b0;
`endif
            state   <= S_DONE;
          end else begin
            // Shift pass feedback: next pass operates on this pass's result
            alu_a     <= alu_y;
            remaining <= remaining - CNT_W'(1);
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef ALU_SEQ_CARRY_CHAIN_EN
  assign alu_cin = 1'b0;
`endif

  alu_seq_rsp_reg u_rsp_reg (
    .clk       (clk),
    .rst       (rst),
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    .carry_ld  (is_adder(alu_op)),
    .carry     (carry),
`endif
    .capture   (capture),
    .consume   (consume),
    .y_in      (alu_y),
    .nvcz_in   (alu_nvcz),
    .rsp_y     (bus.rsp_y),
    .rsp_nvcz  (bus.rsp_nvcz),
    .rsp_valid (bus.rsp_valid)
  );

endmodule
